// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared definitions: sizes, boolean constants
// and the registered commit/rollback output bundle.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_DEF = 8;
  localparam int XLEN         = 32;
  localparam int RW           = 5;

  localparam logic True  = 1'b1;
  localparam logic False = 1'b0;

  typedef struct packed {
    logic            commit_valid;
    logic            rollback;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] pc;
  } rob_out_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with CDB writeback, operand
// forwarding queries and branch-mispredict rollback.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter  int ROB_SIZE = ROB_SIZE_DEF,
  localparam int TW       = $clog2(ROB_SIZE),
  localparam int CW       = $clog2(ROB_SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy,
  input  logic            issue_valid,
  input  logic [RW-1:0]   issue_rd,
  input  logic            issue_isBranch,
  input  logic            issue_predTaken,
  input  logic [XLEN-1:0] issue_altPc,
  output logic [TW-1:0]   issue_rdTag,
  output logic            rob_full,
  input  logic            cdb_valid,
  input  logic [TW-1:0]   cdb_tag,
  input  logic [XLEN-1:0] cdb_val,
  input  logic            cdb_taken,
  input  logic [TW-1:0]   query_Qj,
  input  logic [TW-1:0]   query_Qk,
  output logic            query_Rj,
  output logic            query_Rk,
  output logic [XLEN-1:0] query_Vj,
  output logic [XLEN-1:0] query_Vk,
  output logic            commit_valid,
  output logic [RW-1:0]   ROB_rd,
  output logic [TW-1:0]   ROB_rdTag,
  output logic [XLEN-1:0] ROB_rdVal,
  output logic            rollback,
  output logic [XLEN-1:0] rollback_pc
);

  logic [TW-1:0]       head_q, head_d;
  logic [TW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic [ROB_SIZE-1:0] busy_q, busy_d;
  logic [ROB_SIZE-1:0] ready_q, ready_d;
  logic [ROB_SIZE-1:0] isbr_q, isbr_d;
  logic [ROB_SIZE-1:0] pred_q, pred_d;
  logic [ROB_SIZE-1:0] taken_q, taken_d;
  logic [RW-1:0]       rd_q [ROB_SIZE];
  logic [RW-1:0]       rd_d [ROB_SIZE];
  logic [XLEN-1:0]     val_q [ROB_SIZE];
  logic [XLEN-1:0]     val_d [ROB_SIZE];
  logic [XLEN-1:0]     alt_q [ROB_SIZE];
  logic [XLEN-1:0]     alt_d [ROB_SIZE];
  rob_out_t            out_q, out_d;
  logic [TW-1:0]       otag_q, otag_d;

  logic do_commit;
  logic mispredict;
  logic do_alloc;
  logic cdb_wr;
  logic fwd_j;
  logic fwd_k;

  function automatic logic [TW-1:0] nxt(
    input logic [TW-1:0] p
  );
    if (p == TW'(ROB_SIZE - 1)) return '0;
    return p + TW'(1);
  endfunction

  assign rob_full    = (count_q == CW'(ROB_SIZE));
  assign issue_rdTag = tail_q;

  assign do_commit  = rdy && (count_q != '0)
                   && ready_q[head_q];
  assign mispredict = do_commit && isbr_q[head_q]
                   && (taken_q[head_q] != pred_q[head_q]);
  assign do_alloc   = rdy && issue_valid && !rob_full
                   && !out_q.rollback && !mispredict;
  assign cdb_wr     = rdy && cdb_valid && !out_q.rollback
                   && busy_q[cdb_tag];

  assign fwd_j    = cdb_valid && (cdb_tag == query_Qj);
  assign fwd_k    = cdb_valid && (cdb_tag == query_Qk);
  assign query_Rj = fwd_j || ready_q[query_Qj];
  assign query_Rk = fwd_k || ready_q[query_Qk];
  assign query_Vj = fwd_j ? cdb_val
                  : ready_q[query_Qj] ? val_q[query_Qj]
                  : '0;
  assign query_Vk = fwd_k ? cdb_val
                  : ready_q[query_Qk] ? val_q[query_Qk]
                  : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    isbr_d  = isbr_q;
    pred_d  = pred_q;
    taken_d = taken_q;
    rd_d    = rd_q;
    val_d   = val_q;
    alt_d   = alt_q;
    out_d   = out_q;
    otag_d  = otag_q;
    out_d.commit_valid = False;
    out_d.rollback     = False;
    if (cdb_wr) begin
      ready_d[cdb_tag] = True;
      val_d[cdb_tag]   = cdb_val;
      taken_d[cdb_tag] = cdb_taken;
    end
    if (do_alloc) begin
      busy_d[tail_q]  = True;
      ready_d[tail_q] = False;
      isbr_d[tail_q]  = issue_isBranch;
      pred_d[tail_q]  = issue_predTaken;
      rd_d[tail_q]    = issue_rd;
      alt_d[tail_q]   = issue_altPc;
      tail_d          = nxt(tail_q);
    end
    if (do_commit) begin
      busy_d[head_q]  = False;
      ready_d[head_q] = False;
      head_d          = nxt(head_q);
      if (mispredict) begin
        out_d.rollback = True;
        out_d.pc       = alt_q[head_q];
      end else begin
        out_d.commit_valid = True;
        out_d.rd     = isbr_q[head_q] ? '0 : rd_q[head_q];
        out_d.rd_val = val_q[head_q];
        otag_d       = head_q;
      end
    end
    count_d = count_q + CW'(do_alloc) - CW'(do_commit);
    // A mispredict discards everything younger than the branch
    if (mispredict) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      ready_q <= '0;
      isbr_q  <= '0;
      pred_q  <= '0;
      taken_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        alt_q[i] <= '0;
      end
      out_q  <= '0;
      otag_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      isbr_q  <= isbr_d;
      pred_q  <= pred_d;
      taken_q <= taken_d;
      rd_q    <= rd_d;
      val_q   <= val_d;
      alt_q   <= alt_d;
      out_q   <= out_d;
      otag_q  <= otag_d;
    end
  end

  assign commit_valid = out_q.commit_valid;
  assign rollback     = out_q.rollback;
  assign ROB_rd       = out_q.rd;
  assign ROB_rdVal    = out_q.rd_val;
  assign ROB_rdTag    = otag_q;
  assign rollback_pc  = out_q.pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer against an
// in-order queue model of the buffer.
module tb_reorder_buffer;

  localparam int N = 8;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        rdy = 1;
  logic        issue_valid = 0;
  logic [4:0]  issue_rd = 0;
  logic        issue_isBranch = 0;
  logic        issue_predTaken = 0;
  logic [31:0] issue_altPc = 0;
  logic [2:0]  issue_rdTag;
  logic        rob_full;
  logic        cdb_valid = 0;
  logic [2:0]  cdb_tag = 0;
  logic [31:0] cdb_val = 0;
  logic        cdb_taken = 0;
  logic [2:0]  query_Qj = 0;
  logic [2:0]  query_Qk = 0;
  logic        query_Rj, query_Rk;
  logic [31:0] query_Vj, query_Vk;
  logic        commit_valid;
  logic [4:0]  ROB_rd;
  logic [2:0]  ROB_rdTag;
  logic [31:0] ROB_rdVal;
  logic        rollback;
  logic [31:0] rollback_pc;

  reorder_buffer #(.ROB_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_isBranch(issue_isBranch),
    .issue_predTaken(issue_predTaken),
    .issue_altPc(issue_altPc),
    .issue_rdTag(issue_rdTag), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_val(cdb_val), .cdb_taken(cdb_taken),
    .query_Qj(query_Qj), .query_Qk(query_Qk),
    .query_Rj(query_Rj), .query_Rk(query_Rk),
    .query_Vj(query_Vj), .query_Vk(query_Vk),
    .commit_valid(commit_valid), .ROB_rd(ROB_rd),
    .ROB_rdTag(ROB_rdTag), .ROB_rdVal(ROB_rdVal),
    .rollback(rollback), .rollback_pc(rollback_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    bit [4:0]    rd;
    bit          br, pt, done, tk;
    bit [31:0]   alt, val;
  } ent_t;

  typedef struct {
    bit          rb;
    bit [4:0]    rd;
    bit [2:0]    tag;
    bit [31:0]   val;
  } exp_t;

  ent_t q[$];
  exp_t exq[$];
  int   tail_m = 0;
  bit   rb_m = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, want);
    end
  endtask

  function automatic bit m_ready(input int t,
                                 output bit [31:0] v);
    v = 0;
    foreach (q[i])
      if (q[i].tag == t && q[i].done) begin
        v = q[i].val;
        return 1;
      end
    return 0;
  endfunction

  task automatic qcheck(input string nm,
                        input logic [2:0] qt,
                        input logic r,
                        input logic [31:0] v);
    bit        er;
    bit [31:0] ev;
    er = m_ready(int'(qt), ev);
    if (cdb_valid && cdb_tag == qt) begin
      er = 1;
      ev = cdb_val;
    end
    chk({nm, "_R"}, 32'(r), 32'(er));
    chk({nm, "_V"}, v, ev);
  endtask

  // Drive one cycle from a negedge, check combinational
  // outputs, then advance the model across the posedge.
  task automatic cycle(input bit iv, input bit [4:0] rd,
                       input bit br, input bit pt,
                       input bit [31:0] alt,
                       input bit cv, input bit [2:0] ct,
                       input bit [31:0] cval, input bit ctk,
                       input bit [2:0] qj, input bit [2:0] qk);
    bit   cm, mis, al;
    ent_t e;
    exp_t x;
    issue_valid = iv; issue_rd = rd;
    issue_isBranch = br; issue_predTaken = pt;
    issue_altPc = alt;
    cdb_valid = cv; cdb_tag = ct;
    cdb_val = cval; cdb_taken = ctk;
    query_Qj = qj; query_Qk = qk;
    #1;
    chk("rob_full", 32'(rob_full), 32'(q.size() == N));
    chk("issue_rdTag", 32'(issue_rdTag), 32'(tail_m));
    qcheck("qj", qj, query_Rj, query_Vj);
    qcheck("qk", qk, query_Rk, query_Vk);
    if (rdy) begin
      cm  = q.size() > 0 && q[0].done;
      mis = cm && q[0].br && (q[0].tk != q[0].pt);
      if (cm) begin
        x.rb  = mis;
        x.rd  = q[0].br ? 5'd0 : q[0].rd;
        x.tag = 3'(q[0].tag);
        x.val = mis ? q[0].alt : q[0].val;
        exq.push_back(x);
      end
      if (cv && !rb_m)
        foreach (q[i])
          if (q[i].tag == int'(ct)) begin
            q[i].done = 1;
            q[i].val  = cval;
            q[i].tk   = ctk;
          end
      al = iv && q.size() < N && !rb_m && !mis;
      if (cm) void'(q.pop_front());
      if (mis) begin
        q.delete();
        tail_m = 0;
      end
      if (al) begin
        e.tag = tail_m; e.rd = rd; e.br = br; e.pt = pt;
        e.alt = alt; e.done = 0; e.tk = 0; e.val = 0;
        q.push_back(e);
        tail_m = (tail_m + 1) % N;
      end
      rb_m = mis;
    end else begin
      rb_m = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic iss(input bit [4:0] rd, input bit br,
                     input bit pt, input bit [31:0] alt);
    cycle(1, rd, br, pt, alt, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input bit [2:0] t, input bit [31:0] v,
                    input bit tk);
    cycle(0, 0, 0, 0, 0, 1, t, v, tk, t, 0);
  endtask

  task automatic do_reset();
    issue_valid = 0; cdb_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_commit_valid", 32'(commit_valid), 0);
    chk("rst_rollback", 32'(rollback), 0);
    chk("rst_ROB_rd", 32'(ROB_rd), 0);
    chk("rst_ROB_rdTag", 32'(ROB_rdTag), 0);
    chk("rst_ROB_rdVal", ROB_rdVal, 0);
    chk("rst_rollback_pc", rollback_pc, 0);
    chk("rst_issue_rdTag", 32'(issue_rdTag), 0);
    chk("rst_rob_full", 32'(rob_full), 0);
    q.delete();
    exq.delete();
    tail_m = 0;
    rb_m = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (exq.size() > 0) begin
      x = exq.pop_front();
      if (x.rb) begin
        chk("mon_rollback", 32'(rollback), 1);
        chk("mon_rb_commit", 32'(commit_valid), 0);
        chk("mon_rollback_pc", rollback_pc, x.val);
      end else begin
        chk("mon_commit_valid", 32'(commit_valid), 1);
        chk("mon_rb_low", 32'(rollback), 0);
        chk("mon_ROB_rd", 32'(ROB_rd), 32'(x.rd));
        chk("mon_ROB_rdTag", 32'(ROB_rdTag), 32'(x.tag));
        chk("mon_ROB_rdVal", ROB_rdVal, x.val);
      end
    end else if (commit_valid || rollback) begin
      chk("mon_spurious_pulse",
          {30'd0, commit_valid, rollback}, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit [2:0]  t0;
    bit [2:0]  pend[$];
    bit [31:0] r;
    int        guard;
    @(negedge clk);
    do_reset();

    // in-order commit from out-of-order writeback
    iss(1, 0, 0, 0); iss(2, 0, 0, 0); iss(3, 0, 0, 0);
    wb(2, 32'h22, 0); wb(1, 32'h11, 0); wb(0, 32'h00a, 0);
    repeat (4) idle();

    cycle(0, 0, 0, 0, 0, 1, 4, 32'hDEAD, 0, 4, 4);
    chk("fwd_Rj", 32'(query_Rj), 1);
    chk("fwd_Vj", query_Vj, 32'hDEAD);

    // full and wrap
    do_reset();
    for (int i = 0; i < N; i++) iss(5'(i + 4), 0, 0, 0);
    chk("full_after_8", 32'(rob_full), 1);
    iss(31, 0, 0, 0);
    chk("refused_tag", 32'(issue_rdTag), 0);
    wb(0, 32'h55, 0);
    iss(30, 0, 0, 0);
    iss(29, 0, 0, 0);
    chk("wrap_full", 32'(rob_full), 1);
    chk("wrap_tail", 32'(issue_rdTag), 1);
    for (int i = 1; i < N; i++) wb(3'(i), 32'(i * 3), 0);
    wb(0, 32'h77, 0);
    repeat (3) idle();

    // mispredict
    do_reset();
    iss(7, 0, 0, 0);
    iss(0, 1, 0, 32'h100);
    iss(9, 0, 0, 0);
    wb(0, 32'h1, 0);
    wb(1, 32'h0, 1);
    cycle(1, 4, 0, 0, 0, 1, 2, 32'h9, 0, 2, 0);
    chk("rb_count_zero_tag", 32'(issue_rdTag), 0);
    chk("rb_not_full", 32'(rob_full), 0);
    repeat (2) idle();

    // simultaneous alloc/commit and free-tag writeback
    do_reset();
    iss(3, 0, 0, 0);
    wb(0, 32'h33, 0);
    iss(4, 0, 0, 0);
    chk("same_edge_tag", 32'(issue_rdTag), 2);
    wb(5, 32'hBAD, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1);
    chk("free_tag_Rj", 32'(query_Rj), 0);
    wb(1, 32'h44, 0);
    repeat (2) idle();

    // rdy low freezes state
    iss(6, 0, 0, 0);
    idle();
    t0 = issue_rdTag;
    rdy = 0;
    repeat (3) cycle(1, 8, 0, 0, 0, 1, t0 - 3'd1,
                     32'h5, 0, 0, 0);
    chk("rdy_tag_hold", 32'(issue_rdTag), 32'(t0));
    rdy = 1;
    wb(t0 - 3'd1, 32'h66, 0);
    repeat (2) idle();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      pend.delete();
      foreach (q[i]) if (!q[i].done) pend.push_back(3'(q[i].tag));
      r = $urandom;
      rdy = ($urandom_range(0, 9) != 0);
      if (pend.size() > 0 && r[3:0] < 11)
        t0 = pend[$urandom_range(0, pend.size() - 1)];
      else
        t0 = 3'($urandom);
      cycle($urandom_range(0, 9) < 6, 5'($urandom),
            $urandom_range(0, 3) == 0, r[8], $urandom,
            r[3:0] < 13, t0, $urandom, r[9],
            3'($urandom), 3'($urandom));
      if (c == 200) begin
        rdy = 1;
        do_reset();
      end
    end

    // drain
    rdy = 1;
    guard = 0;
    while ((q.size() > 0 || exq.size() > 0) && guard < 100) begin
      t0 = 3'(tail_m);
      foreach (q[i])
        if (!q[i].done) begin
          t0 = 3'(q[i].tag);
          break;
        end
      cycle(0, 0, 0, 0, 0, q.size() > 0, t0,
            $urandom, 0, t0, 0);
      guard++;
    end
    chk("drain_bound", 32'(guard < 100), 1);
    repeat (2) idle();
    chk("scoreboard_empty", 32'(exq.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 8, the entry count; tags are `ROBRange` and 3 bits wide at the default.
REQ-002 SHALL have ports clk (input, 1, the single clock) and rst_n (input, 1); reset is asynchronous and active-low.
REQ-003 SHALL have rdy (input, 1); when low, all state freezes.
REQ-004 SHALL have issue_valid (input, 1), an allocation request from the dispatcher.
REQ-005 SHALL have issue_rd (input, 5), the destination register; 0 means no destination.
REQ-006 SHALL have issue_isBranch and issue_predTaken (inputs, 1 each), the branch flag and its prediction.
REQ-007 SHALL have issue_altPc (input, 32), the PC to resume at if the prediction is wrong.
REQ-008 SHALL have issue_rdTag (output, `ROBRange`), the tail tag granted this cycle.
REQ-009 SHALL have rob_full (output, 1), the allocation stall.
REQ-010 SHALL have cdb_valid (input, 1), cdb_tag (input, `ROBRange`), cdb_val (input, 32) and cdb_taken (input, 1), the writeback bus.
REQ-011 SHALL have query_Qj and query_Qk (inputs, `ROBRange`), each paired with outputs query_Rj/query_Rk (1) and query_Vj/query_Vk (32), for operand forwarding.
REQ-012 SHALL have outputs commit_valid (1), ROB_rd (5), ROB_rdTag (`ROBRange`) and ROB_rdVal (32), driven to the register file.
REQ-013 SHALL have outputs rollback (1) and rollback_pc (32), driven to the register file, the reservation stations and the fetcher.

Function
REQ-014 SHALL be a circular buffer with head, tail and count registers; pointers wrap from ROB_SIZE-1 to 0.
REQ-015 SHALL assert rob_full combinationally when count==ROB_SIZE; a same-cycle commit does not lift it.
REQ-016 SHALL drive issue_rdTag = tail at all times.
REQ-017 SHALL allocate on a posedge with rdy && issue_valid && !rob_full && !rollback: the entry is marked busy and not ready, its fields are stored, and tail and count increment.
REQ-018 SHALL, on cdb_valid, set ready and store val and taken in entry cdb_tag; a write to a non-busy entry is ignored.
REQ-019 SHALL drive query_Rj as 1 if entry Qj is ready or cdb_valid&&cdb_tag==Qj; query_Vj comes from the CDB when it matches, else from the entry, else 0. Qk behaves the same.
REQ-020 SHALL commit at most one entry per cycle: when count>0 and the head is ready, the head is freed on the posedge and head increments.
REQ-021 SHALL register commit outputs: commit_valid is a one-cycle pulse in the cycle after the commit edge, with ROB_rd, ROB_rdTag = old head, and ROB_rdVal.
REQ-022 SHALL treat a committed branch with taken!=predTaken as a mispredict: commit_valid=0, rollback=1 for one cycle, rollback_pc=altPc, all entries cleared, and head=tail=count=0.
REQ-023 SHALL give a correctly predicted branch commit_valid=1 with ROB_rd=0.
REQ-024 SHALL keep count unchanged when allocation and commit occur on the same edge.
REQ-025 SHALL, while rollback is high, ignore both allocation and CDB writes.
REQ-026 SHALL, while rdy is low, hold commit_valid and rollback at 0 and keep all other state unchanged.

Reset
REQ-027 SHALL, on rst_n low and regardless of clk, clear head, tail, count and every busy/ready bit, and drive commit_valid, rollback, ROB_rd, ROB_rdTag, ROB_rdVal and rollback_pc to 0.
REQ-028 SHALL treat reset asserted mid-operation as abandoning all in-flight entries, with no commit pulse.

Structure
REQ-029 SHALL take `ROBRange`, ROB_SIZE, `True` and `False` from defines.v, which is shared with the register file and the reservation stations.
REQ-030 SHALL be a single module with no sub-module; the entry storage is flat register arrays indexed by tag.

Verification
REQ-031 SHALL cover in-order commit: allocate 3 entries (rd=1,2,3); CDB writes tags 2,1,0 in successive cycles -> commits in tag order 0,1,2, with ROB_rdVal matching each write.
REQ-032 SHALL cover full and wrap: allocate 8 entries -> rob_full=1 and a 9th issue is refused; commit 1 and allocate 1 -> the new entry gets tag 0 and count=8.
REQ-033 SHALL cover mispredict: a branch at tag 1 with predTaken=0, altPc=0x100 receives cdb_taken=1 -> rollback=1 for one cycle, rollback_pc=0x100, count=0, and no commit_valid for that entry.
REQ-034 SHALL cover forwarding: query_Qj=4 in the same cycle as cdb_valid with tag 4 and value 0xDEAD -> query_Rj=1 and query_Vj=0xDEAD.
REQ-035 SHALL cover simultaneous events: allocate and commit on the same edge -> count unchanged; a CDB write to a free tag -> no state change.
REQ-036 SHALL cover async reset and rdy: asserting rst_n low between edges clears the outputs immediately; with rdy=0 for 3 cycles, head, tail and count are unchanged.
